// File: rtl/conv1_scheduler.sv
// conv1_scheduler
// ----------------------------------------------------------------------------
// Time-multiplexed sequencer for the first convolution layer. Walks every
// OUT_W x OUT_W output position of an IMG_W x IMG_W float8 image. For each
// position it fetches the K x K window from image memory, issues it to a
// shared external conv unit, waits for the bias-added result and writes that
// result to output memory.
//
// Optional build macro: CONV1_SCHED_REUSE_EN
//   When defined, pixels with col>0 shift the window left by one column and
//   fetch only the K new right-column elements. Output data is identical.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin a layer pass (sampled only in IDLE)
//   busy, done        pass in progress / one-cycle end-of-pass pulse
//   img_rd_en/addr    image memory read strobe and address
//   img_data          image read data, valid one cycle after img_rd_en
//   win_data/valid    packed window (k=0 in MSB byte) and issue strobe
//   conv_result/valid/overflow  result from the conv unit
//   out_we/addr/data  output memory write port
//   overflow          sticky OR of accepted conv_overflow during the pass
// ----------------------------------------------------------------------------
module conv1_scheduler #(
    parameter int IMG_W = 28,
    parameter int K     = 5,
    parameter int OUT_W = 24,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             img_rd_en,
    output logic [AW-1:0]    img_addr,
    input  logic [7:0]       img_data,
    output logic [K*K*8-1:0] win_data,
    output logic             win_valid,
    input  logic [7:0]       conv_result,
    input  logic             conv_valid,
    input  logic             conv_overflow,
    output logic             out_we,
    output logic [AW-1:0]    out_addr,
    output logic [7:0]       out_data,
    output logic             overflow
);

    localparam int N  = K * K;
    localparam int CW = $clog2(OUT_W);
    localparam int FW = $clog2(K);
    localparam int SW = $clog2(N);
    localparam logic [CW-1:0] POS_LAST = CW'(OUT_W - 1);
    localparam logic [FW-1:0] K_LAST   = FW'(K - 1);

`ifdef CONV1_SCHED_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DRAIN, S_ISSUE, S_WAIT_RES, S_WRITE, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   row_q, row_d, col_q, col_d;
    logic [FW-1:0]   fr_q, fr_d, fc_q, fc_d;     // window (r,c) of the read issued this cycle
    logic            rd_v_q;                     // img_data carries a requested byte this cycle
    logic [SW-1:0]   rd_slot_q;                  // window slot that byte belongs to
    logic [7:0]      win_q [N];
    logic            busy_q, done_q, img_rd_en_q, win_valid_q, out_we_q, ovf_q, ovf_d;
    logic [AW-1:0]   img_addr_q, img_addr_d, out_addr_q, out_addr_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            shift_s, col_only_s;
    logic [SW-1:0]   slot_s;
    logic [N*8-1:0]  win_pack_s;

    function automatic logic [AW-1:0] img_addr_f(input logic [CW-1:0] row, input logic [CW-1:0] col,
                                                 input logic [FW-1:0] r, input logic [FW-1:0] c);
        return (AW'(row) + AW'(r)) * AW'(IMG_W) + AW'(col) + AW'(c);
    endfunction

    assign col_only_s = REUSE && (col_q != {CW{1'b0}});
    assign slot_s     = SW'(fr_q) * SW'(K) + SW'(fc_q);

    // Next-state, counter and datapath-capture logic.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        fr_d       = fr_q;
        fc_d       = fc_q;
        out_data_d = out_data_q;
        ovf_d      = ovf_q;
        shift_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    row_d   = {CW{1'b0}};
                    col_d   = {CW{1'b0}};
                    fr_d    = {FW{1'b0}};
                    fc_d    = {FW{1'b0}};
                    ovf_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (fr_q == K_LAST && fc_q == K_LAST) begin
                    state_d = S_DRAIN;
                end else if (col_only_s || fc_q == K_LAST) begin
                    // Column-only fetch stays on c=K-1 and walks r.
                    fr_d = fr_q + FW'(1);
                    fc_d = col_only_s ? K_LAST : {FW{1'b0}};
                end else begin
                    fc_d = fc_q + FW'(1);
                end
            end
            S_DRAIN:    state_d = S_ISSUE;
            S_ISSUE:    state_d = S_WAIT_RES;
            S_WAIT_RES: begin
                if (conv_valid) begin
                    out_data_d = conv_result;
                    ovf_d      = ovf_q | conv_overflow;
                    state_d    = S_WRITE;
                end else begin
                    state_d = S_WAIT_RES;
                end
            end
            S_WRITE: begin
                fr_d = {FW{1'b0}};
                if (col_q < POS_LAST) begin
                    col_d   = col_q + CW'(1);
                    state_d = S_FETCH;
                    shift_s = REUSE;
                    fc_d    = REUSE ? K_LAST : {FW{1'b0}};
                end else begin
                    col_d = {CW{1'b0}};
                    fc_d  = {FW{1'b0}};
                    if (row_q < POS_LAST) begin
                        row_d   = row_q + CW'(1);
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_FETCH) begin
            img_addr_d = img_addr_f(row_d, col_d, fr_d, fc_d);
        end else begin
            img_addr_d = {AW{1'b0}};
        end
        out_addr_d = AW'(row_d) * AW'(OUT_W) + AW'(col_d);
    end

    // Registers; outputs are registered from next-state so they align with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_q       <= {CW{1'b0}};
            col_q       <= {CW{1'b0}};
            fr_q        <= {FW{1'b0}};
            fc_q        <= {FW{1'b0}};
            rd_v_q      <= 1'b0;
            rd_slot_q   <= {SW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            img_rd_en_q <= 1'b0;
            img_addr_q  <= {AW{1'b0}};
            win_valid_q <= 1'b0;
            out_we_q    <= 1'b0;
            out_addr_q  <= {AW{1'b0}};
            out_data_q  <= 8'h00;
            ovf_q       <= 1'b0;
            for (int i = 0; i < N; i++) begin
                win_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            fr_q        <= fr_d;
            fc_q        <= fc_d;
            rd_v_q      <= (state_q == S_FETCH);
            rd_slot_q   <= slot_s;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            img_rd_en_q <= (state_d == S_FETCH);
            img_addr_q  <= img_addr_d;
            win_valid_q <= (state_d == S_ISSUE);
            out_we_q    <= (state_d == S_WRITE);
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
            if (shift_s) begin
                for (int i = 0; i < N - 1; i++) begin
                    if ((i % K) != K - 1) begin
                        win_q[i] <= win_q[i+1];
                    end
                end
            end
            if (rd_v_q) begin
                win_q[rd_slot_q] <= img_data;
            end
        end
    end

    // Pack the window with element k=0 in the most significant byte.
    always_comb begin
        win_pack_s = {(N*8){1'b0}};
        for (int k = 0; k < N; k++) begin
            win_pack_s[(N-1-k)*8 +: 8] = win_q[k];
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign img_rd_en = img_rd_en_q;
    assign img_addr  = img_addr_q;
    assign win_data  = win_pack_s;
    assign win_valid = win_valid_q;
    assign out_we    = out_we_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/conv1_scheduler.md
Name: conv1_scheduler

Overview:
Time-multiplexed sequencer for the first convolution layer. It walks all 24x24 output positions of a 28x28 float8 image. For each position it fetches the 5x5 window from image memory, issues the window to one shared 25-tap conv unit (conv core plus bias adder, external), waits for the result, and writes it to output memory. It replaces the fully-unrolled 576-instance conv1 array wherever area matters more than latency.

Parameters:
IMG_W, 28, input image width/height in pixels
K, 5, kernel width/height
OUT_W, 24, output width/height; must equal IMG_W-K+1
AW, 10, address width of image and output memories

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin a layer pass; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until DONE exits
done  out  1  one-cycle pulse when the last output has been written
img_rd_en  out  1  image memory read strobe
img_addr  out  AW  image read address = (row+r)*IMG_W + (col+c)
img_data  in  8  image read data; valid exactly 1 cycle after img_rd_en
win_data  out  K*K*8  window to conv unit; element k=r*K+c at bits [(K*K-1-k)*8 +: 8], so k=0 is in the MSB byte
win_valid  out  1  one-cycle issue strobe; win_data is stable while high
conv_result  in  8  bias-added float8 result
conv_valid  in  1  result strobe, at least 1 cycle after win_valid
conv_overflow  in  1  overflow flag qualified by conv_valid
out_we  out  1  output memory write strobe
out_addr  out  AW  row*OUT_W + col
out_data  out  8  registered conv_result
overflow  out  1  sticky OR of all qualified conv_overflow in the current pass

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, row=col=0, window cleared. busy, done, img_rd_en, win_valid, out_we and overflow are 0. img_addr, out_addr, out_data and win_data are 0.
- Reset mid-pass aborts immediately. There is no write after reset. Results arriving later are ignored.
- FSM states: IDLE, FETCH, DRAIN, ISSUE, WAIT_RES, WRITE, DONE.
- IDLE: on start=1, go to FETCH. Accepting start clears overflow and sets row=col=0.
- FETCH: one read per cycle with img_rd_en=1. Element order is k=0..N-1, row-major within the window; N=25. The byte returned for read k is stored in window slot k one cycle later. After the last read, go to DRAIN.
- DRAIN: 1 cycle; captures the final element; img_rd_en=0.
- ISSUE: win_valid=1 for exactly 1 cycle, then go to WAIT_RES.
- WAIT_RES: hold until conv_valid=1. On that cycle, latch conv_result into out_data and OR conv_overflow into overflow, then go to WRITE.
- WRITE: out_we=1 for 1 cycle. Then:
  - col<OUT_W-1: col++, go to FETCH.
  - else col<-0; if row<OUT_W-1: row++, go to FETCH; else go to DONE.
- DONE: done=1 for 1 cycle, busy drops, go to IDLE.
- Per-pixel cycle count: 25+1+1+L+1, where L = cycles from win_valid to conv_valid. Full pass = 576*(28+L) cycles, plus the DONE cycle.
- start outside IDLE is ignored. conv_valid outside WAIT_RES is ignored. start held high gives back-to-back passes with 1 idle cycle between them.
- Address arithmetic is unsigned and at most 783, so it never wraps in AW=10.

Optional Feature:
CONV1_SCHED_REUSE_EN
- Defined: when col>0, the window shifts left one column. Slot k takes slot k+1 for c<K-1. FETCH then reads only the 5 new right-column elements (c=K-1, r=0..4), in r order.
  - Per-pixel cost is 8+L.
  - The first column of each row still does a full 25-read fetch.
- Undefined: every pixel performs a full 25-read fetch.
- Output data is identical with and without the feature.

Test Plan:
1. Reset check: drive rst_n=0 with random inputs. All outputs must read 0. start pulsed while rst_n=0 must have no effect.
2. Full pass: img[a]=a mod 256. The conv model returns the window MSB byte with L=1.
   - Output memory must satisfy out[r*24+c]=img[r*28+c] for all 576 entries.
   - done must fire 16704 cycles after start is accepted; 5664 cycles with REUSE_EN.
   - Exactly 576 out_we pulses; the last out_addr is 575.
3. Window order: a ramp image with the conv model checking win_data bytes against the expected 25-element row-major pattern at positions (0,0), (0,23), (23,0) and (23,23). Any mismatch flags an error.
4. Overflow: conv_overflow=1 only at position (5,7). overflow must go high in the WRITE of out_addr 127 and stay high until done. The next accepted start must clear it.
5. Protocol: vary L between 1 and 7 randomly. Pulse start mid-pass, which must be ignored. Issue a stray conv_valid in FETCH, which must be ignored. Output must match scenario 2.
6. Abort: assert rst_n=0 at out_addr 300. Must return to IDLE with no further out_we. A new start must complete a clean full pass.
